// File: rtl/cdf_engine.sv
// Purpose: walks NUM_BINS histogram bins, writes back the running (saturating) CDF, reports cdf_min/cdf_total.
// Latency: MEM_RD_LAT+2 cycles per bin with wr_ready high; done pulses the cycle after the last write is accepted.
// Backpressure: WRITE holds wr_en/wr_addr/wr_data stable until wr_ready; no new read is issued meanwhile.
module cdf_engine #(
    parameter int NUM_BINS   = 64,
    parameter int ADDR_W     = 6,
    parameter int HIST_W     = 16,
    parameter int CDF_W      = 22,
    parameter int MEM_RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [HIST_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [CDF_W-1:0]  wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic [CDF_W-1:0]  cdf_min,
    output logic [CDF_W-1:0]  cdf_total,
    output logic              overflow
);

    // Latency counter only needs to count the extra WAIT cycles (MEM_RD_LAT-2 down to 0).
    localparam int LAT_W = (MEM_RD_LAT > 2) ? $clog2(MEM_RD_LAT - 1) : 1;
    localparam logic [LAT_W-1:0]  WAIT_INIT = LAT_W'((MEM_RD_LAT > 2) ? (MEM_RD_LAT - 2) : 0);
    localparam logic [ADDR_W-1:0] LAST_BIN  = ADDR_W'(NUM_BINS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_ACCUM = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LAT_W-1:0]   lat_cnt;
    logic [ADDR_W-1:0]  bin;
    logic [CDF_W-1:0]   acc;
    logic [CDF_W-1:0]   acc_nxt;
    logic [CDF_W:0]     sum_wide;
    logic               min_found;

    // State register; reset abandons any pass in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every transition, including start in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_READ;
            S_READ:  state_nxt = (MEM_RD_LAT == 1) ? S_ACCUM : S_WAIT;
            S_WAIT:  if (lat_cnt == '0) state_nxt = S_ACCUM;
            S_ACCUM: state_nxt = S_WRITE;
            S_WRITE: begin
                if (wr_ready) begin
                    state_nxt = (bin == LAST_BIN) ? S_DONE : S_READ;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
        end
    end

    // Saturating accumulate: one extra bit catches the carry, which clamps the sum to all-ones.
    always_comb begin
        sum_wide = {1'b0, acc} + (CDF_W + 1)'(rd_data);
        acc_nxt  = sum_wide[CDF_W] ? '1 : sum_wide[CDF_W-1:0];
    end

    // Datapath registers; an abort freezes everything, so results keep their last values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt   <= '0;
            bin       <= '0;
            acc       <= '0;
            min_found <= 1'b0;
            cdf_min   <= '0;
            cdf_total <= '0;
            overflow  <= 1'b0;
        end else if (!abort) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bin       <= '0;
                        acc       <= '0;
                        min_found <= 1'b0;
                        cdf_min   <= '0;
                        overflow  <= 1'b0;
                    end
                end
                S_READ: begin
                    lat_cnt <= WAIT_INIT;
                end
                S_WAIT: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                S_ACCUM: begin
                    acc <= acc_nxt;
                    if (sum_wide[CDF_W]) begin
                        overflow <= 1'b1;
                    end
                    if ((rd_data != '0) && !min_found) begin
                        cdf_min   <= acc_nxt;
                        min_found <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (wr_ready) begin
                        if (bin == LAST_BIN) begin
                            cdf_total <= acc;
                        end else begin
                            bin <= bin + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Request and status outputs decode only registered state, so no input reaches them combinationally.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        if (state == S_READ) begin
            rd_en   = 1'b1;
            rd_addr = bin;
        end
        if (state == S_WRITE) begin
            wr_en   = 1'b1;
            wr_addr = bin;
            wr_data = acc;
        end
    end

endmodule

// File: tb/tb_cdf_engine.sv
module tb_cdf_engine;

    localparam int A_BINS = 64, A_ADDR = 6, A_HIST = 16, A_CDF = 22, A_LAT = 2;
    localparam int B_BINS = 8,  B_ADDR = 3, B_HIST = 16, B_CDF = 17, B_LAT = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    logic              start_a, abort_a, rd_en_a, wr_en_a, wr_ready_a, busy_a, done_a, overflow_a;
    logic [A_ADDR-1:0] rd_addr_a, wr_addr_a;
    logic [A_HIST-1:0] rd_data_a;
    logic [A_CDF-1:0]  wr_data_a, cdf_min_a, cdf_total_a;

    logic              start_b, abort_b, rd_en_b, wr_en_b, wr_ready_b, busy_b, done_b, overflow_b;
    logic [B_ADDR-1:0] rd_addr_b, wr_addr_b;
    logic [B_HIST-1:0] rd_data_b;
    logic [B_CDF-1:0]  wr_data_b, cdf_min_b, cdf_total_b;

    cdf_engine #(.NUM_BINS(A_BINS), .ADDR_W(A_ADDR), .HIST_W(A_HIST), .CDF_W(A_CDF), .MEM_RD_LAT(A_LAT)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_ready(wr_ready_a),
        .busy(busy_a), .done(done_a), .cdf_min(cdf_min_a), .cdf_total(cdf_total_a), .overflow(overflow_a)
    );

    cdf_engine #(.NUM_BINS(B_BINS), .ADDR_W(B_ADDR), .HIST_W(B_HIST), .CDF_W(B_CDF), .MEM_RD_LAT(B_LAT)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_ready(wr_ready_b),
        .busy(busy_b), .done(done_b), .cdf_min(cdf_min_b), .cdf_total(cdf_total_b), .overflow(overflow_b)
    );

    always #5 clk = ~clk;

    // Scratch memory models: read data appears MEM_RD_LAT cycles after the address.
    logic [15:0] mem_a [A_BINS];
    logic [15:0] mem_b [B_BINS];
    logic [15:0] pa0, pa1, pb0;
    always @(posedge clk) begin
        pa0 <= mem_a[rd_addr_a];
        pa1 <= pa0;
        pb0 <= mem_b[rd_addr_b];
    end
    assign rd_data_a = pa1;
    assign rd_data_b = pb0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct { logic [7:0] addr; logic [23:0] data; } wr_t;
    typedef struct { logic [23:0] mn; logic [23:0] tot; logic ovf; } res_t;
    wr_t  wq_a[$], wq_b[$];
    res_t rq_a[$], rq_b[$];
    wr_t  wa, wb;
    res_t ra, rb;

    task automatic push_w(input bit to_b, input int addr, input int data);
        wr_t w;
        w.addr = 8'(addr);
        w.data = 24'(data);
        if (to_b) wq_b.push_back(w); else wq_a.push_back(w);
    endtask

    task automatic push_r(input bit to_b, input int mn, input int tot, input bit ovf);
        res_t r;
        r.mn = 24'(mn);
        r.tot = 24'(tot);
        r.ovf = ovf;
        if (to_b) rq_b.push_back(r); else rq_a.push_back(r);
    endtask

    // Monitor A: every accepted write and every done pulse is checked against the scoreboard.
    always @(negedge clk) begin
        if (reset_n && wr_en_a && wr_ready_a && !abort_a) begin
            chk("a_wr_expected", 64'(wq_a.size() > 0), 1);
            if (wq_a.size() > 0) begin
                wa = wq_a.pop_front();
                chk("a_wr_addr", 64'(wr_addr_a), 64'(wa.addr));
                chk("a_wr_data", 64'(wr_data_a), 64'(wa.data));
            end
        end
        if (reset_n && done_a) begin
            chk("a_done_expected", 64'(rq_a.size() > 0), 1);
            if (rq_a.size() > 0) begin
                ra = rq_a.pop_front();
                chk("a_cdf_min", 64'(cdf_min_a), 64'(ra.mn));
                chk("a_cdf_total", 64'(cdf_total_a), 64'(ra.tot));
                chk("a_overflow", 64'(overflow_a), 64'(ra.ovf));
            end
        end
    end

    // Monitor B: same scoreboard checks for the narrow, single-cycle-latency build.
    always @(negedge clk) begin
        if (reset_n && wr_en_b && wr_ready_b && !abort_b) begin
            chk("b_wr_expected", 64'(wq_b.size() > 0), 1);
            if (wq_b.size() > 0) begin
                wb = wq_b.pop_front();
                chk("b_wr_addr", 64'(wr_addr_b), 64'(wb.addr));
                chk("b_wr_data", 64'(wr_data_b), 64'(wb.data));
            end
        end
        if (reset_n && done_b) begin
            chk("b_done_expected", 64'(rq_b.size() > 0), 1);
            if (rq_b.size() > 0) begin
                rb = rq_b.pop_front();
                chk("b_cdf_min", 64'(cdf_min_b), 64'(rb.mn));
                chk("b_cdf_total", 64'(cdf_total_b), 64'(rb.tot));
                chk("b_overflow", 64'(overflow_b), 64'(rb.ovf));
            end
        end
    end

    // Pulse start, then count cycles (from the cycle after start is sampled) until done.
    task automatic run_a(input int budget, input int restart_at, output int t_rd, output int t_done);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        t_rd = -1;
        t_done = -1;
        for (int n = 0; n < budget && t_done < 0; n++) begin
            @(negedge clk);
            start_a = (n == restart_at);
            if (n == 0) chk("a_busy_after_start", 64'(busy_a), 1);
            if (rd_en_a && t_rd < 0) t_rd = n;
            if (done_a) t_done = n;
        end
        start_a = 1'b0;
        chk("a_done_seen", 64'(t_done >= 0), 1);
        @(posedge clk); #1;
        chk("a_wq_drained", 64'(wq_a.size()), 0);
        chk("a_rq_drained", 64'(rq_a.size()), 0);
    endtask

    task automatic run_b(input int budget, output int t_rd, output int t_done);
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        t_rd = -1;
        t_done = -1;
        for (int n = 0; n < budget && t_done < 0; n++) begin
            @(negedge clk);
            if (rd_en_b && t_rd < 0) t_rd = n;
            if (done_b) t_done = n;
        end
        chk("b_done_seen", 64'(t_done >= 0), 1);
        @(posedge clk); #1;
        chk("b_wq_drained", 64'(wq_b.size()), 0);
        chk("b_rq_drained", 64'(rq_b.size()), 0);
    endtask

    // Hold wr_ready low for the first 5 cycles of the bin-7 write (all-ones memory, so data is 8).
    task automatic stall_a();
        int cnt = 0;
        int rds = 0;
        bit trig = 1'b0;
        for (int n = 0; n < 300 && !trig; n++) begin
            @(negedge clk);
            if (rd_en_a && rd_addr_a == 6'd7) trig = 1'b1;
        end
        chk("a_stall_trigger", 64'(trig), 1);
        wr_ready_a = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (rd_en_a) rds++;
            if (wr_en_a) begin
                cnt++;
                chk("a_stall_addr", 64'(wr_addr_a), 7);
                chk("a_stall_data", 64'(wr_data_a), 8);
            end
            if (wr_en_a && wr_ready_a) break;
            if (cnt == 5) begin
                @(posedge clk); #1 wr_ready_a = 1'b1;
            end
        end
        wr_ready_a = 1'b1;
        chk("a_stall_cycles", 64'(cnt), 6);
        chk("a_stall_no_rd", 64'(rds), 0);
    endtask

    task automatic load_ones_a();
        for (int i = 0; i < A_BINS; i++) mem_a[i] = 16'd1;
        for (int i = 0; i < A_BINS; i++) push_w(1'b0, i, i + 1);
        push_r(1'b0, 1, 64, 1'b0);
    endtask

    initial begin
        int t_rd, t_done, acc, rd_cnt, wr_cnt, dn_cnt;
        bit seen;
        start_a = 0; abort_a = 0; wr_ready_a = 1;
        start_b = 0; abort_b = 0; wr_ready_b = 1;
        for (int i = 0; i < A_BINS; i++) mem_a[i] = '0;
        for (int i = 0; i < B_BINS; i++) mem_b[i] = '0;

        // Reset values
        #1 reset_n = 1'b0;
        #2;
        chk("rst_rd_en", 64'(rd_en_a), 0);
        chk("rst_rd_addr", 64'(rd_addr_a), 0);
        chk("rst_wr_en", 64'(wr_en_a), 0);
        chk("rst_wr_data", 64'(wr_data_a), 0);
        chk("rst_busy", 64'(busy_a), 0);
        chk("rst_done", 64'(done_a), 0);
        chk("rst_cdf_min", 64'(cdf_min_a), 0);
        chk("rst_cdf_total", 64'(cdf_total_a), 0);
        chk("rst_overflow", 64'(overflow_a), 0);
        chk("rst_b_busy", 64'(busy_b), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Every bin 1: CDF 1..64, 4 cycles per bin
        load_ones_a();
        run_a(400, -1, t_rd, t_done);
        chk("a_pass_len_ones", 64'(t_done - t_rd), 256);

        // Same data with a 5-cycle write stall at bin 7
        load_ones_a();
        fork
            run_a(400, -1, t_rd, t_done);
            stall_a();
        join
        chk("a_pass_len_stall", 64'(t_done - t_rd), 261);

        // Leading zeros: bins 0..9 = 0, bin 10 = 5, rest 2
        acc = 0;
        for (int i = 0; i < A_BINS; i++) begin
            mem_a[i] = (i < 10) ? 16'd0 : (i == 10) ? 16'd5 : 16'd2;
            acc += int'(mem_a[i]);
            push_w(1'b0, i, acc);
        end
        push_r(1'b0, 5, 111, 1'b0);
        run_a(400, -1, t_rd, t_done);
        chk("a_pass_len_zeros", 64'(t_done - t_rd), 256);

        // Abort in WAIT of bin 20
        for (int i = 0; i < A_BINS; i++) mem_a[i] = 16'd1;
        for (int i = 0; i < 20; i++) push_w(1'b0, i, i + 1);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (rd_en_a && rd_addr_a == 6'd20) seen = 1'b1;
        end
        chk("a_abort_reached_bin20", 64'(seen), 1);
        @(posedge clk); #1 abort_a = 1'b1;
        @(posedge clk); #1 abort_a = 1'b0;
        @(negedge clk);
        chk("a_abort_busy", 64'(busy_a), 0);
        rd_cnt = 0; wr_cnt = 0; dn_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rd_en_a) rd_cnt++;
            if (wr_en_a) wr_cnt++;
            if (done_a) dn_cnt++;
        end
        chk("a_abort_no_rd", 64'(rd_cnt), 0);
        chk("a_abort_no_wr", 64'(wr_cnt), 0);
        chk("a_abort_no_done", 64'(dn_cnt), 0);
        chk("a_abort_cdf_min", 64'(cdf_min_a), 1);
        chk("a_abort_cdf_total", 64'(cdf_total_a), 111);
        chk("a_abort_wq_drained", 64'(wq_a.size()), 0);

        // start together with abort in IDLE stays idle
        @(posedge clk); #1 start_a = 1'b1; abort_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0; abort_a = 1'b0;
        @(negedge clk);
        chk("a_start_abort_idle", 64'(busy_a), 0);

        // Fresh pass after abort, with a stray start mid-pass that must be ignored
        load_ones_a();
        run_a(400, 100, t_rd, t_done);
        chk("a_pass_len_restart", 64'(t_done - t_rd), 256);

        // Asynchronous reset between clock edges mid-pass
        load_ones_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (50) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy_a), 0);
        chk("arst_rd_en", 64'(rd_en_a), 0);
        chk("arst_wr_en", 64'(wr_en_a), 0);
        chk("arst_wr_data", 64'(wr_data_a), 0);
        chk("arst_cdf_min", 64'(cdf_min_a), 0);
        chk("arst_cdf_total", 64'(cdf_total_a), 0);
        wq_a.delete();
        rq_a.delete();
        @(negedge clk);
        reset_n = 1'b1;
        dn_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done_a || busy_a) dn_cnt++;
        end
        chk("arst_stays_idle", 64'(dn_cnt), 0);

        // Narrow build: CDF_W=17, every bin 0xFFFF, single-cycle read latency
        for (int i = 0; i < B_BINS; i++) mem_b[i] = 16'hFFFF;
        push_w(1'b1, 0, 'h0FFFF);
        push_w(1'b1, 1, 'h1FFFE);
        for (int i = 2; i < B_BINS; i++) push_w(1'b1, i, 'h1FFFF);
        push_r(1'b1, 'h0FFFF, 'h1FFFF, 1'b1);
        run_b(100, t_rd, t_done);
        chk("b_pass_len_lat1", 64'(t_done - t_rd), 24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
